rs_dsp_multacc_pipe: RTL and testbench

RS_DSP_MULTACC_PIPE -- requirements
Module: rs_dsp_multacc_pipe

---
 rtl/rs_dsp_pkg.sv | 22 ++
 rtl/rs_dsp_round_sat.sv | 65 ++++++
 rtl/rs_dsp_multacc_pipe.sv | 176 +++++++++++++++++
 tb/tb_rs_dsp_multacc_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_dsp_pkg.sv
// Shared types and elaboration-time legality checks for the rs_dsp multiply-accumulate slice.
// Feedback mode encoding is common to the pipeline and anything that drives it.
package rs_dsp_pkg;

    typedef enum logic [1:0] {
        FB_MULT = 2'b00,
        FB_ACC  = 2'b01,
        FB_LOAD = 2'b10
    } fb_mode_e;

    localparam int SHIFT_WIDTH   = 6;
    localparam int IN_STAGES_MIN = 0;
    localparam int IN_STAGES_MAX = 3;

    // The accumulator must hold a full signed product and the whole output range.
    function automatic bit widths_legal(input int a_w, input int b_w, input int z_w,
                                        input int acc_w, input int in_stages);
        return (acc_w >= a_w + b_w + 1) && (acc_w >= z_w) && (z_w >= 2) &&
               (in_stages >= IN_STAGES_MIN) && (in_stages <= IN_STAGES_MAX);
    endfunction

endpackage

// File: rtl/rs_dsp_round_sat.sv
// Output conditioning: optional round-half-up, arithmetic right shift, clamp to Z range.
// Rounding hardware exists only when RS_DSP_ROUND_EN is defined; otherwise round is ignored.
module rs_dsp_round_sat
    import rs_dsp_pkg::*;
#(
    parameter int ACC_WIDTH = 48,
    parameter int Z_WIDTH   = 38
) (
    input  logic signed [ACC_WIDTH-1:0]   v,
    input  logic        [SHIFT_WIDTH-1:0] shift_right,
    input  logic                          round,
    input  logic                          saturate,
    output logic        [Z_WIDTH-1:0]     z,
    output logic                          ovf
);

    // One guard bit so the rounding add can never wrap.
    localparam int EW = ACC_WIDTH + 1;
    localparam logic signed [EW-1:0] Z_MAX = {{(EW-Z_WIDTH+1){1'b0}}, {(Z_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] Z_MIN = {{(EW-Z_WIDTH+1){1'b1}}, {(Z_WIDTH-1){1'b0}}};

    logic signed [EW-1:0] v_ext;
    logic signed [EW-1:0] v_rnd;
    logic signed [EW-1:0] v_shr;

    assign v_ext = EW'(v);

`ifdef RS_DSP_ROUND_EN
    logic signed [EW-1:0] rnd_add;

    always_comb begin
        rnd_add = '0;
        if (round && (shift_right != '0) && (int'(shift_right) < ACC_WIDTH)) begin
            rnd_add = EW'(1) << (int'(shift_right) - 1);
        end
    end

    assign v_rnd = v_ext + rnd_add;
`else
    logic unused_round;

    assign unused_round = round;
    assign v_rnd        = v_ext;
`endif

    // Shifts at or beyond the accumulator width collapse to the sign of v.
    always_comb begin
        if (int'(shift_right) >= ACC_WIDTH) begin
            v_shr = v[ACC_WIDTH-1] ? '1 : '0;
        end else begin
            v_shr = v_rnd >>> shift_right;
        end
    end

    assign ovf = (v_shr > Z_MAX) || (v_shr < Z_MIN);

    always_comb begin
        if (saturate && ovf) begin
            z = v_shr[EW-1] ? Z_MIN[Z_WIDTH-1:0] : Z_MAX[Z_WIDTH-1:0];
        end else begin
            z = v_shr[Z_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/rs_dsp_multacc_pipe.sv
// Pipelined signed/unsigned multiply-accumulate: IN_STAGES input regs, multiply reg, acc/output reg.
// Optional rounding in the output stage is enabled by the RS_DSP_ROUND_EN macro.
module rs_dsp_multacc_pipe
    import rs_dsp_pkg::*;
#(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 18,
    parameter int Z_WIDTH   = 38,
    parameter int ACC_WIDTH = 48,
    parameter int IN_STAGES = 1
) (
    input  logic                   clk,
    input  logic                   lreset,
    input  logic                   in_valid,
    input  logic [A_WIDTH-1:0]     a,
    input  logic [B_WIDTH-1:0]     b,
    input  logic                   unsigned_a,
    input  logic                   unsigned_b,
    input  logic [1:0]             feedback,
    input  logic                   subtract,
    input  logic [SHIFT_WIDTH-1:0] shift_right,
    input  logic                   round,
    input  logic                   saturate,
    input  logic                   clear_sat,
    output logic                   out_valid,
    output logic [Z_WIDTH-1:0]     z,
    output logic                   sat_flag
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH + 1;

    if (!widths_legal(A_WIDTH, B_WIDTH, Z_WIDTH, ACC_WIDTH, IN_STAGES)) begin : g_param_check
        $error("rs_dsp_multacc_pipe: illegal width/stage parameters");
    end

    typedef struct packed {
        logic                   valid;
        logic [A_WIDTH-1:0]     a;
        logic [B_WIDTH-1:0]     b;
        logic                   ua;
        logic                   ub;
        logic [1:0]             fb;
        logic                   sub;
        logic [SHIFT_WIDTH-1:0] sh;
        logic                   rnd;
        logic                   sat;
        logic                   clr;
    } in_beat_t;

    typedef struct packed {
        logic                        valid;
        logic signed [ACC_WIDTH-1:0] q;
        logic [1:0]                  fb;
        logic [SHIFT_WIDTH-1:0]      sh;
        logic                        rnd;
        logic                        sat;
        logic                        clr;
    } mult_beat_t;

    in_beat_t in_beat;
    in_beat_t in_d;

    assign in_beat = '{valid: in_valid, a: a, b: b, ua: unsigned_a, ub: unsigned_b,
                       fb: feedback, sub: subtract, sh: shift_right, rnd: round,
                       sat: saturate, clr: clear_sat};

    if (IN_STAGES == 0) begin : g_no_in_reg
        assign in_d = in_beat;
    end else begin : g_in_reg
        for (genvar gi = 0; gi < IN_STAGES; gi++) begin : g_stage
            in_beat_t stage_reg;
            in_beat_t stage_next;
            if (gi == 0) begin : g_head
                assign stage_next = in_beat;
            end else begin : g_link
                assign stage_next = g_stage[gi-1].stage_reg;
            end
            always_ff @(posedge clk or posedge lreset) begin
                if (lreset) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= stage_next;
                end
            end
        end
        assign in_d = g_stage[IN_STAGES-1].stage_reg;
    end

    // Multiply stage: one extra bit per operand makes signed and unsigned share one multiplier.
    logic signed [A_WIDTH:0]       a_ext;
    logic signed [B_WIDTH:0]       b_ext;
    logic signed [P_WIDTH-1:0]     p;
    logic signed [ACC_WIDTH-1:0]   p_ext;
    logic signed [ACC_WIDTH-1:0]   q_next;
    mult_beat_t                    m_next;
    mult_beat_t                    m_reg;

    assign a_ext  = {in_d.a[A_WIDTH-1] & ~in_d.ua, in_d.a};
    assign b_ext  = {in_d.b[B_WIDTH-1] & ~in_d.ub, in_d.b};
    assign p      = P_WIDTH'(a_ext) * P_WIDTH'(b_ext);
    assign p_ext  = ACC_WIDTH'(p);
    assign q_next = in_d.sub ? -p_ext : p_ext;
    assign m_next = '{valid: in_d.valid, q: q_next, fb: in_d.fb, sh: in_d.sh,
                      rnd: in_d.rnd, sat: in_d.sat, clr: in_d.clr};

    always_ff @(posedge clk or posedge lreset) begin
        if (lreset) begin
            m_reg <= '0;
        end else begin
            m_reg <= m_next;
        end
    end

    // Accumulate / output stage. Reserved mode 2'b11 falls into the MULT path.
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic                        acc_load;
    logic [Z_WIDTH-1:0]          z_next;
    logic                        ovf;
    logic [Z_WIDTH-1:0]          z_reg;
    logic                        out_valid_reg;
    logic                        sat_flag_reg;

    always_comb begin
        acc_next = m_reg.q;
        acc_load = 1'b0;
        case (m_reg.fb)
            FB_ACC: begin
                acc_next = acc_reg + m_reg.q;
                acc_load = 1'b1;
            end
            FB_LOAD: acc_load = 1'b1;
            default: acc_load = 1'b0;
        endcase
    end

    rs_dsp_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .Z_WIDTH   (Z_WIDTH)
    ) u_round_sat (
        .v           (acc_next),
        .shift_right (m_reg.sh),
        .round       (m_reg.rnd),
        .saturate    (m_reg.sat),
        .z           (z_next),
        .ovf         (ovf)
    );

    always_ff @(posedge clk or posedge lreset) begin
        if (lreset) begin
            acc_reg       <= '0;
            z_reg         <= '0;
            out_valid_reg <= 1'b0;
            sat_flag_reg  <= 1'b0;
        end else begin
            out_valid_reg <= m_reg.valid;
            if (m_reg.valid) begin
                z_reg <= z_next;
                if (acc_load) begin
                    acc_reg <= acc_next;
                end
                // A beat that overflows wins over its own clear request.
                if (ovf) begin
                    sat_flag_reg <= 1'b1;
                end else if (m_reg.clr) begin
                    sat_flag_reg <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign z         = z_reg;
    assign sat_flag  = sat_flag_reg;

endmodule

// File: tb/tb_rs_dsp_multacc_pipe.sv
// Randomized + directed bench for rs_dsp_multacc_pipe against an arithmetic reference model.
// Expected rounding behaviour follows the RS_DSP_ROUND_EN macro.
module tb_rs_dsp_multacc_pipe;

    localparam int AW   = 20;
    localparam int BW   = 18;
    localparam int ZW   = 38;
    localparam int ACCW = 48;
    localparam int INS  = 1;
    localparam int LAT  = INS + 2;
`ifdef RS_DSP_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif
    localparam longint ZMAX_L = (longint'(1) << (ZW - 1)) - 1;
    localparam longint ZMIN_L = -(longint'(1) << (ZW - 1));

    logic          clk = 1'b0;
    logic          lreset;
    logic          in_valid;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          unsigned_a;
    logic          unsigned_b;
    logic [1:0]    feedback;
    logic          subtract;
    logic [5:0]    shift_right;
    logic          round;
    logic          saturate;
    logic          clear_sat;
    logic          out_valid;
    logic [ZW-1:0] z;
    logic          sat_flag;

    rs_dsp_multacc_pipe #(
        .A_WIDTH   (AW),
        .B_WIDTH   (BW),
        .Z_WIDTH   (ZW),
        .ACC_WIDTH (ACCW),
        .IN_STAGES (INS)
    ) dut (
        .clk         (clk),
        .lreset      (lreset),
        .in_valid    (in_valid),
        .a           (a),
        .b           (b),
        .unsigned_a  (unsigned_a),
        .unsigned_b  (unsigned_b),
        .feedback    (feedback),
        .subtract    (subtract),
        .shift_right (shift_right),
        .round       (round),
        .saturate    (saturate),
        .clear_sat   (clear_sat),
        .out_valid   (out_valid),
        .z           (z),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [ZW-1:0] z;
        bit            sat;
        bit            has_want;
        logic [ZW-1:0] want;
    } exp_t;

    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    longint        acc_m   = 0;
    bit            sat_m   = 1'b0;
    logic [ZW-1:0] last_z  = '0;
    bit            last_sat = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    function automatic longint sext(input longint x, input int w);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        acc_m    = 0;
        sat_m    = 1'b0;
        last_z   = '0;
        last_sat = 1'b0;
    endtask

    task automatic check_outputs();
        exp_t e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("stray_beat", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("z", 64'(z), 64'(e.z));
                if (e.has_want) chk("z_directed", 64'(z), 64'(e.want));
                chk("sat_flag", 64'(sat_flag), 64'(e.sat));
                last_z   = e.z;
                last_sat = e.sat;
                $display("[TB] cyc=%0d z=%0d sat_flag=%0b", cyc, $signed(z), sat_flag);
            end
        end else begin
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                chk("missing_beat", 64'(out_valid), 64'd1);
                e = exp_q.pop_front();
            end
            chk("z_hold", 64'(z), 64'(last_z));
            chk("sat_hold", 64'(sat_flag), 64'(last_sat));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Drive one cycle of inputs; valid beats are run through the reference model.
    task automatic beat(input bit vld, input logic [AW-1:0] ai, input logic [BW-1:0] bi,
                        input bit uai, input bit ubi, input logic [1:0] fb, input bit subi,
                        input logic [5:0] sh, input bit rndi, input bit sati, input bit clri,
                        input bit has_want = 1'b0, input logic [ZW-1:0] want = '0);
        exp_t   e;
        longint av, bv, q, v, s;
        bit     ovf;
        in_valid = vld; a = ai; b = bi; unsigned_a = uai; unsigned_b = ubi;
        feedback = fb; subtract = subi; shift_right = sh; round = rndi;
        saturate = sati; clear_sat = clri;
        if (vld) begin
            av = uai ? longint'(ai) : sext(longint'(ai), AW);
            bv = ubi ? longint'(bi) : sext(longint'(bi), BW);
            q  = av * bv;
            if (subi) q = -q;
            case (fb)
                2'b01: begin v = sext(acc_m + q, ACCW); acc_m = v; end
                2'b10: begin v = q; acc_m = q; end
                default: v = q;
            endcase
            if (ROUND_EN && rndi && sh != 0 && int'(sh) < ACCW) v = v + (longint'(1) << (sh - 1));
            if (int'(sh) >= ACCW) s = (v < 0) ? -1 : 0;
            else s = v >>> sh;
            ovf = (s > ZMAX_L) || (s < ZMIN_L);
            if (sati && ovf) s = (s < 0) ? ZMIN_L : ZMAX_L;
            if (ovf) sat_m = 1'b1;
            else if (clri) sat_m = 1'b0;
            e.cyc = cyc + LAT; e.z = s[ZW-1:0]; e.sat = sat_m;
            e.has_want = has_want; e.want = want;
            exp_q.push_back(e);
        end
        tick();
    endtask

    function automatic logic [AW-1:0] rand_a();
        case ($urandom_range(0, 5))
            0: return 20'hFFFFF;
            1: return 20'h80000;
            2: return 20'h7FFFF;
            default: return AW'($urandom);
        endcase
    endfunction

    function automatic logic [BW-1:0] rand_b();
        case ($urandom_range(0, 5))
            0: return 18'h3FFFF;
            1: return 18'h20000;
            2: return 18'h1FFFF;
            default: return BW'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lreset = 1'b1; in_valid = 1'b0; a = '0; b = '0; unsigned_a = 1'b0; unsigned_b = 1'b0;
        feedback = 2'b00; subtract = 1'b0; shift_right = '0; round = 1'b0;
        saturate = 1'b0; clear_sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_z", 64'(z), 64'd0);
        chk("reset_sat_flag", 64'(sat_flag), 64'd0);
        model_reset();
        lreset = 1'b0;

        // Signed MULT, unsigned/signed interpretation of the same operand.
        beat(1, 20'd3, BW'(-5), 0, 0, 2'b00, 0, 6'd0, 0, 0, 0, 1, ZW'(-15));
        idle(LAT + 1);
        beat(1, 20'hFFFFF, 18'd2, 1, 0, 2'b00, 0, 6'd0, 0, 0, 0, 1, ZW'(2097150));
        beat(1, 20'hFFFFF, 18'd2, 0, 0, 2'b00, 0, 6'd0, 0, 0, 0, 1, ZW'(-2));
        idle(LAT + 1);

        // LOAD then back-to-back ACC, last one subtracting.
        beat(1, 20'd100, 18'd100, 0, 0, 2'b10, 0, 6'd0, 0, 0, 0, 1, ZW'(10000));
        beat(1, 20'd100, 18'd100, 0, 0, 2'b01, 0, 6'd0, 0, 0, 0, 1, ZW'(20000));
        beat(1, 20'd100, 18'd100, 0, 0, 2'b01, 0, 6'd0, 0, 0, 0, 1, ZW'(30000));
        beat(1, 20'd100, 18'd100, 0, 0, 2'b01, 0, 6'd0, 0, 0, 0, 1, ZW'(40000));
        beat(1, 20'd100, 18'd100, 0, 0, 2'b01, 1, 6'd0, 0, 0, 0, 1, ZW'(30000));
        idle(LAT + 1);

        // Saturating accumulation, then clear via a benign beat.
        beat(1, 20'h7FFFF, 18'h1FFFF, 0, 0, 2'b10, 0, 6'd0, 0, 1, 0);
        beat(1, 20'h7FFFF, 18'h1FFFF, 0, 0, 2'b01, 0, 6'd0, 0, 1, 0);
        beat(1, 20'h7FFFF, 18'h1FFFF, 0, 0, 2'b01, 0, 6'd0, 0, 1, 0);
        beat(1, 20'h7FFFF, 18'h1FFFF, 0, 0, 2'b01, 0, 6'd0, 0, 1, 0, 1, ZW'(ZMAX_L));
        idle(LAT + 1);
        chk("sat_flag_set", 64'(sat_flag), 64'd1);
        beat(1, 20'd1, 18'd1, 0, 0, 2'b00, 0, 6'd0, 0, 0, 1, 1, ZW'(1));
        idle(LAT + 1);
        chk("sat_flag_cleared", 64'(sat_flag), 64'd0);

        // Rounding, oversized shift, reserved mode leaving acc untouched.
        beat(1, 20'd7, 18'd1, 0, 0, 2'b00, 0, 6'd1, 1, 0, 0, 1, ROUND_EN ? ZW'(4) : ZW'(3));
        beat(1, 20'hFFFFF, 18'd1, 0, 0, 2'b00, 0, 6'd50, 1, 0, 0, 1, ZW'(-1));
        beat(1, 20'd100, 18'd100, 0, 0, 2'b10, 0, 6'd0, 0, 0, 0, 1, ZW'(10000));
        beat(1, 20'd2, 18'd3, 0, 0, 2'b11, 0, 6'd0, 0, 0, 0, 1, ZW'(6));
        beat(1, 20'd5, 18'd1, 0, 0, 2'b00, 0, 6'd0, 0, 0, 0, 1, ZW'(5));
        beat(1, 20'd100, 18'd100, 0, 0, 2'b01, 0, 6'd0, 0, 0, 0, 1, ZW'(20000));
        idle(LAT + 1);

        // Reset with one beat emerging and two in flight.
        beat(1, 20'hFFFFF, 18'h3FFFF, 1, 1, 2'b00, 0, 6'd0, 0, 0, 0);
        idle(LAT + 1);
        beat(1, 20'd3, BW'(-5), 0, 0, 2'b00, 0, 6'd0, 0, 0, 0, 1, ZW'(-15));
        beat(1, 20'd9, 18'd9, 0, 0, 2'b10, 0, 6'd0, 0, 0, 0);
        beat(1, 20'd8, 18'd8, 0, 0, 2'b01, 0, 6'd0, 0, 0, 0);
        in_valid = 1'b0;
        #2;
        lreset = 1'b1;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_z", 64'(z), 64'd0);
        chk("midreset_sat_flag", 64'(sat_flag), 64'd0);
        model_reset();
        tick();
        lreset = 1'b0;
        beat(1, 20'd100, 18'd100, 0, 0, 2'b01, 0, 6'd0, 0, 0, 0, 1, ZW'(10000));
        idle(LAT + 2);

        repeat (400) begin
            beat($urandom_range(0, 3) != 0, rand_a(), rand_b(),
                 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 ($urandom_range(0, 9) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 24)),
                 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
        end
        idle(LAT + 2);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
